divn_sm: RTL and testbench

Parametrised divide-by-N state machine: a modulo-N phase counter that advances on each enabled clock and decodes a pulse or square-wave output from its phase. Replaces the fixed divide-by-3 machine in the clock-enable and strobe generation path. Adds a runtime-programmable divisor, glitch-free divisor changes at period boundaries, a terminal-count strobe and a rejected-load error flag.

---
 rtl/divn_sm.sv | 107 ++++++++++
 tb/tb_divn_sm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/divn_sm.sv
`timescale 1ns/1ps
// divn_sm: modulo-N phase counter with a programmable divisor. It decodes a pulse output
//   (or a square output when DIVN_SQUARE_EN is defined) and a terminal-count strobe.
// Latency: count, div_cur and err update one edge after the enabling/loading cycle;
//   y and tc are decoded combinationally from state (tc also uses enable).
// Backpressure: none. enable gates every state change except load capture and err.
// Ports: clk, reset_n (async, active-low), enable, load, div_in[WIDTH], mode (ignored
//   unless DIVN_SQUARE_EN is defined) -> y, tc, count[WIDTH], div_cur[WIDTH], err.
// Divisor loads are parked in a shadow register and applied only at a wrap edge,
// so a period is never cut short or stretched mid-way.
module divn_sm #(
    parameter int WIDTH       = 8,
    parameter int DIV_DEFAULT = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode,
    output logic             y,
    output logic             tc,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] div_cur,
    output logic             err
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_DEFAULT);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] div_cur_nxt;
    logic [WIDTH-1:0] div_pend;
    logic [WIDTH-1:0] div_pend_nxt;
    logic             pend;
    logic             pend_nxt;
    logic             err_nxt;
    logic             at_last;
    logic             wrap;
    logic             load_ok;

    // div_cur is never 0, so div_cur-1 cannot underflow.
    assign at_last = (cnt == div_cur - WIDTH'(1));
    assign wrap    = enable & at_last;
    assign load_ok = load & (div_in != '0);

    always_comb begin
        cnt_nxt      = cnt;
        div_cur_nxt  = div_cur;
        div_pend_nxt = div_pend;
        pend_nxt     = pend;
        err_nxt      = err;

        if (load && (div_in == '0)) begin
            err_nxt = 1'b1;
        end

        if (enable) begin
            cnt_nxt = at_last ? '0 : cnt + WIDTH'(1);
        end

        if (wrap) begin
            // A load arriving on the wrap edge bypasses the shadow register and
            // is newer than anything already pending.
            pend_nxt = 1'b0;
            if (load_ok) begin
                div_cur_nxt = div_in;
            end else if (pend) begin
                div_cur_nxt = div_pend;
            end
        end else if (load_ok) begin
            div_pend_nxt = div_in;
            pend_nxt     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            div_cur  <= DIV_RST;
            div_pend <= DIV_RST;
            pend     <= 1'b0;
            err      <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            div_cur  <= div_cur_nxt;
            div_pend <= div_pend_nxt;
            pend     <= pend_nxt;
            err      <= err_nxt;
        end
    end

    assign count = cnt;
    assign tc    = wrap;

`ifdef DIVN_SQUARE_EN
    // One extra bit so that ceil(N/2) stays correct for N = 2^WIDTH-1.
    logic [WIDTH:0] sq_half;
    assign sq_half = ({1'b0, div_cur} + (WIDTH+1)'(1)) >> 1;
    assign y       = mode ? ({1'b0, cnt} < sq_half) : (cnt == '0);
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign y           = (cnt == '0);
`endif

endmodule

// File: tb/tb_divn_sm.sv
`timescale 1ns/1ps
module tb_divn_sm;

`ifdef DIVN_SQUARE_EN
    localparam bit SQ = 1'b1;
`else
    localparam bit SQ = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       load;
    logic [7:0] div_in;
    logic       mode;
    logic       y;
    logic       tc;
    logic [7:0] count;
    logic [7:0] div_cur;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Reference model: phase, active divisor, queued divisor (0 = none), error flag.
    int m_phase;
    int m_n;
    int m_queued;
    bit m_err;

    divn_sm #(.WIDTH(8), .DIV_DEFAULT(3)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
        .div_in(div_in), .mode(mode), .y(y), .tc(tc), .count(count),
        .div_cur(div_cur), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase  = 0;
        m_n      = 3;
        m_queued = 0;
        m_err    = 1'b0;
    endtask

    // One enabled edge either finishes the current period or moves one phase on.
    // A finished period adopts the newest requested divisor (same-edge request wins).
    task automatic model_step(input bit en, input bit ld, input int din);
        bit period_done;
        period_done = en && (m_phase == m_n - 1);
        if (ld && din == 0) m_err = 1'b1;
        if (ld && din != 0) m_queued = din;
        if (en) m_phase = (m_phase + 1) % m_n;
        if (period_done && m_queued != 0) begin
            m_n      = m_queued;
            m_queued = 0;
        end
    endtask

    function automatic bit model_y(input bit md);
        if (SQ && md) return m_phase < (m_n + 1) / 2;
        return m_phase == 0;
    endfunction

    function automatic bit model_tc(input bit en);
        return en && (m_phase == m_n - 1);
    endfunction

    // Called at a falling edge: apply inputs, settle, leave room for sampling.
    task automatic set_in(input bit en, input bit ld, input int din, input bit md);
        enable = en;
        load   = ld;
        div_in = 8'(din);
        mode   = md;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(enable, load, int'(div_in));
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_in(1, 0, 0, 0);
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (div_cur !== 8'd3) begin errors++; $display("FAIL reset_div got %0d exp 3", div_cur); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (y !== 1'b1) begin errors++; $display("FAIL reset_y got %b exp 1", y); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got %b exp 0", tc); end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_default_sequence();
        for (int i = 0; i < 9; i++) begin
            set_in(1, 0, 0, 0);
            checks++; if (count !== 8'(i % 3)) begin errors++; $display("FAIL seq_count[%0d] got %0d exp %0d", i, count, i % 3); end
            checks++; if (y !== (i % 3 == 0)) begin errors++; $display("FAIL seq_y[%0d] got %b exp %b", i, y, (i % 3 == 0)); end
            checks++; if (tc !== (i % 3 == 2)) begin errors++; $display("FAIL seq_tc[%0d] got %b exp %b", i, tc, (i % 3 == 2)); end
            tick();
        end
    endtask

    task automatic test_enable_gating();
        set_in(1, 0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, 0);
            checks++; if (count !== 8'd1) begin errors++; $display("FAIL gate_count[%0d] got %0d exp 1", i, count); end
            checks++; if (tc !== 1'b0) begin errors++; $display("FAIL gate_tc[%0d] got %b exp 0", i, tc); end
            tick();
        end
        set_in(1, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0);
        checks++; if (count !== 8'd2) begin errors++; $display("FAIL gate_resume got %0d exp 2", count); end
    endtask

    task automatic test_deferred_load();
        tick();                      // wrap to 0
        set_in(1, 1, 5, 0);
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL defer_start got %0d exp 0", count); end
        tick();
        for (int i = 1; i < 3; i++) begin
            set_in(1, 0, 0, 0);
            checks++; if (div_cur !== 8'd3 || count !== 8'(i)) begin
                errors++; $display("FAIL defer_hold[%0d] got div %0d cnt %0d exp div 3 cnt %0d", i, div_cur, count, i);
            end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 0);
            checks++; if (div_cur !== 8'd5 || count !== 8'(i)) begin
                errors++; $display("FAIL defer_new[%0d] got div %0d cnt %0d exp div 5 cnt %0d", i, div_cur, count, i);
            end
            checks++; if (tc !== (i == 4)) begin errors++; $display("FAIL defer_tc[%0d] got %b exp %b", i, tc, (i == 4)); end
            tick();
        end
    endtask

    task automatic test_wrap_load_and_zero();
        for (int i = 0; i < 4; i++) begin set_in(1, 0, 0, 0); tick(); end
        set_in(1, 1, 2, 0);
        checks++; if (count !== 8'd4) begin errors++; $display("FAIL wrapld_pre got %0d exp 4", count); end
        tick();
        for (int i = 0; i < 6; i++) begin
            set_in(1, 0, 0, 0);
            checks++; if (div_cur !== 8'd2 || count !== 8'(i % 2)) begin
                errors++; $display("FAIL wrapld[%0d] got div %0d cnt %0d exp div 2 cnt %0d", i, div_cur, count, i % 2);
            end
            tick();
        end
        set_in(0, 1, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0);
            checks++; if (err !== 1'b1 || div_cur !== 8'd2) begin
                errors++; $display("FAIL zero_load[%0d] got err %b div %0d exp err 1 div 2", i, err, div_cur);
            end
            tick();
        end
    endtask

    task automatic wait_div(input int n, input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < 600; k++) begin
            set_in(1, 0, 0, 0);
            if (div_cur == 8'(n) && count == 8'd0) begin hit = 1'b1; break; end
            tick();
        end
        checks++; if (!hit) begin errors++; $display("FAIL %s_timeout got div %0d exp %0d", tag, div_cur, n); end
    endtask

    task automatic test_square();
        set_in(1, 1, 5, 0);
        tick();
        wait_div(5, "sq5");
        for (int i = 0; i < 10; i++) begin
            bit exp_y;
            exp_y = SQ ? ((i % 5) < 3) : ((i % 5) == 0);
            set_in(1, 0, 0, 1);
            checks++; if (y !== exp_y) begin errors++; $display("FAIL sq5_y[%0d] got %b exp %b", i, y, exp_y); end
            tick();
        end
        set_in(1, 1, 1, 0);
        tick();
        wait_div(1, "n1");
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, i[0]);
            checks++; if (y !== 1'b1 || tc !== 1'b1 || count !== 8'd0) begin
                errors++; $display("FAIL n1[%0d] got y %b tc %b cnt %0d exp 1 1 0", i, y, tc, count);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        set_in(1, 1, 7, 0);
        tick();
        wait_div(7, "n7");
        for (int i = 0; i < 4; i++) begin set_in(1, 0, 0, 0); tick(); end
        set_in(0, 1, 9, 0);
        checks++; if (count !== 8'd4) begin errors++; $display("FAIL ar_pre got %0d exp 4", count); end
        tick();
        set_in(0, 0, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        checks++; if (count !== 8'd0 || div_cur !== 8'd3 || err !== 1'b0) begin
            errors++; $display("FAIL ar_immediate got cnt %0d div %0d err %b exp 0 3 0", count, div_cur, err);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_in(1, 0, 0, 0);
            checks++; if (div_cur !== 8'd3 || count !== 8'(i % 3)) begin
                errors++; $display("FAIL ar_after[%0d] got div %0d cnt %0d exp div 3 cnt %0d", i, div_cur, count, i % 3);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit en, ld, md;
            int din;
            en  = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 9) == 0);
            md  = $urandom_range(0, 1);
            din = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            set_in(en, ld, din, md);
            checks++; if (count !== 8'(m_phase) || div_cur !== 8'(m_n) || err !== m_err ||
                          y !== model_y(md) || tc !== model_tc(en)) begin
                errors++;
                $display("FAIL rand[%0d] got cnt %0d div %0d err %b y %b tc %b exp %0d %0d %b %b %b",
                         i, count, div_cur, err, y, tc, m_phase, m_n, m_err, model_y(md), model_tc(en));
            end
            tick();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        div_in  = 8'd0;
        mode    = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_default_sequence();
        test_enable_gating();
        test_deferred_load();
        test_wrap_load_and_zero();
        test_square();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
